// File: rtl/vga_dac_pkg.sv
// Shared definitions for the VGA DAC port controller: port offsets, DAC
// read/write state codes, colour component codes and the prefetch FSM states.
package vga_dac_pkg;

  localparam logic [1:0] DAC_PEL_MASK = 2'd0;
  localparam logic [1:0] DAC_RD_IDX   = 2'd1;
  localparam logic [1:0] DAC_WR_IDX   = 2'd2;
  localparam logic [1:0] DAC_DATA     = 2'd3;

  localparam logic [1:0] DAC_ST_WRITE = 2'b00;
  localparam logic [1:0] DAC_ST_READ  = 2'b11;

  localparam logic [1:0] COMP_R = 2'd0;
  localparam logic [1:0] COMP_G = 2'd1;
  localparam logic [1:0] COMP_B = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    RD_CAP   = 2'd3
  } pf_state_e;

  function automatic logic [9:0] ram_byte_addr(input logic [7:0] idx, input logic [1:0] comp);
    return {idx, comp};
  endfunction

endpackage

// File: rtl/dac_triplet_ctr.sv
// Palette index + colour component counter: R,G,B then on to the next index.
// The lookahead outputs let the parent address the RAM with the post-advance value.
module dac_triplet_ctr
  import vga_dac_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_load_idx,
  input  logic       i_adv,
  output logic [7:0] o_idx,
  output logic [1:0] o_comp,
  output logic [7:0] o_next_idx,
  output logic [1:0] o_next_comp
);

  logic [7:0] r_idx;
  logic [1:0] r_comp;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_next_idx  = r_idx;
    o_next_comp = r_comp + 2'd1;
    if (r_comp == COMP_B) begin
      o_next_comp = COMP_R;
      o_next_idx  = r_idx + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx  <= 8'd0;
      r_comp <= COMP_R;
    end else if (i_load) begin
      r_idx  <= i_load_idx;
      r_comp <= COMP_R;
    end else if (i_adv) begin
      r_idx  <= o_next_idx;
      r_comp <= o_next_comp;
    end
  end

  assign o_idx  = r_idx;
  assign o_comp = r_comp;

endmodule

// File: rtl/vga_dac_port_ctrl.sv
// CPU-side VGA DAC controller (ports 3C6..3C9): triplet sequencing, PEL mask
// and a one-entry read-back prefetch from the palette RAM byte port.
module vga_dac_port_ctrl
  import vga_dac_pkg::*;
#(
  parameter logic [7:0] MASK_RST  = 8'hFF,
  parameter int         COMP_BITS = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_ce,
  input  logic       io_wr,
  input  logic [1:0] io_addr,
  input  logic [7:0] io_din,
  output logic [7:0] io_dout,
  output logic       io_ready,
  output logic       ram_ce,
  output logic       ram_we,
  output logic [9:0] ram_addr,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout,
  output logic [7:0] pel_mask
);

  localparam logic [7:0] COMP_MASK = 8'((9'd1 << COMP_BITS) - 9'd1);

  pf_state_e  r_state;
  logic [7:0] r_pel_mask, r_io_dout, r_ram_din, r_pf_data;
  logic [9:0] r_ram_addr;
  logic [1:0] r_dac_state;
  logic       r_io_ready, r_ram_ce, r_ram_we, r_pf_valid, r_pf_pend;

  logic [7:0] w_widx, w_ridx, w_ridx_nxt, w_widx_nxt;
  logic [1:0] w_wcomp, w_rcomp, w_rcomp_nxt, w_wcomp_nxt;
  logic       w_access, w_idle_acc, w_cap_rd, w_is_data;
  logic       w_wr_load, w_rd_load, w_wr_adv, w_rd_adv, w_pf_hit;

  // The host holds io_ce through the ready cycle, so never re-accept while ready is high.
  assign w_access   = io_ce && !r_io_ready;
  assign w_is_data  = (io_addr == DAC_DATA);
  assign w_idle_acc = (r_state == IDLE) && !r_pf_pend && w_access;
  assign w_cap_rd   = (r_state == RD_CAP) && w_access && !io_wr && w_is_data;
  assign w_wr_load  = w_idle_acc && io_wr && (io_addr == DAC_WR_IDX);
  assign w_rd_load  = w_idle_acc && io_wr && (io_addr == DAC_RD_IDX);
  assign w_wr_adv   = w_idle_acc && io_wr && w_is_data;
  assign w_rd_adv   = (w_idle_acc && !io_wr && w_is_data && r_pf_valid) || w_cap_rd;
  assign w_pf_hit   = r_pf_valid && ({w_widx, w_wcomp} == {w_ridx, w_rcomp});

  dac_triplet_ctr u_wr_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_wr_load),
    .i_load_idx (io_din),
    .i_adv      (w_wr_adv),
    .o_idx      (w_widx),
    .o_comp     (w_wcomp),
    .o_next_idx (w_widx_nxt),
    .o_next_comp(w_wcomp_nxt)
  );

  dac_triplet_ctr u_rd_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_rd_load),
    .i_load_idx (io_din),
    .i_adv      (w_rd_adv),
    .o_idx      (w_ridx),
    .o_comp     (w_rcomp),
    .o_next_idx (w_ridx_nxt),
    .o_next_comp(w_rcomp_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pel_mask  <= MASK_RST;
      r_dac_state <= DAC_ST_WRITE;
      r_io_dout   <= 8'd0;
      r_io_ready  <= 1'b0;
      r_ram_ce    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= 10'd0;
      r_ram_din   <= 8'd0;
      r_pf_data   <= 8'd0;
      r_pf_valid  <= 1'b0;
      r_pf_pend   <= 1'b0;
    end else begin
      r_io_ready <= 1'b0;
      r_ram_ce   <= 1'b0;
      r_ram_we   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_pf_pend) begin
            // Re-fetch after a data write overwrote the byte held in the prefetch.
            r_pf_pend  <= 1'b0;
            r_state    <= RD_ISSUE;
            r_ram_ce   <= 1'b1;
            r_ram_addr <= ram_byte_addr(w_ridx, w_rcomp);
          end else if (w_access && io_wr) begin
            r_io_ready <= 1'b1;
            case (io_addr)
              DAC_PEL_MASK: r_pel_mask <= io_din;
              DAC_RD_IDX: begin
                r_dac_state <= DAC_ST_READ;
                r_pf_valid  <= 1'b0;
                r_state     <= RD_ISSUE;
                r_ram_ce    <= 1'b1;
                r_ram_addr  <= ram_byte_addr(io_din, COMP_R);
              end
              DAC_WR_IDX: r_dac_state <= DAC_ST_WRITE;
              default: begin
                r_ram_ce   <= 1'b1;
                r_ram_we   <= 1'b1;
                r_ram_addr <= ram_byte_addr(w_widx, w_wcomp);
                r_ram_din  <= io_din & COMP_MASK;
                if (w_pf_hit) begin
                  r_pf_valid <= 1'b0;
                  r_pf_pend  <= 1'b1;
                end
              end
            endcase
          end else if (w_access) begin
            case (io_addr)
              DAC_PEL_MASK: begin
                r_io_ready <= 1'b1;
                r_io_dout  <= r_pel_mask;
              end
              DAC_RD_IDX: begin
                r_io_ready <= 1'b1;
                r_io_dout  <= {6'b0, r_dac_state};
              end
              DAC_WR_IDX: begin
                r_io_ready <= 1'b1;
                r_io_dout  <= w_widx;
              end
              default: begin
                r_state  <= RD_ISSUE;
                r_ram_ce <= 1'b1;
                if (r_pf_valid) begin
                  r_io_ready <= 1'b1;
                  r_io_dout  <= r_pf_data;
                  r_pf_valid <= 1'b0;
                  r_ram_addr <= ram_byte_addr(w_ridx_nxt, w_rcomp_nxt);
                end else begin
                  // Nothing prefetched yet: fetch now, the read is served from RD_CAP.
                  r_ram_addr <= ram_byte_addr(w_ridx, w_rcomp);
                end
              end
            endcase
          end
        end
        RD_ISSUE: r_state <= RD_WAIT;
        RD_WAIT:  r_state <= RD_CAP;
        default: begin
          if (w_cap_rd) begin
            // A data read stalled on this fetch takes the byte straight from the RAM.
            r_io_ready <= 1'b1;
            r_io_dout  <= ram_dout;
            r_state    <= RD_ISSUE;
            r_ram_ce   <= 1'b1;
            r_ram_addr <= ram_byte_addr(w_ridx_nxt, w_rcomp_nxt);
          end else begin
            r_pf_data  <= ram_dout;
            r_pf_valid <= 1'b1;
            r_state    <= IDLE;
          end
        end
      endcase
    end
  end

  assign io_dout  = r_io_dout;
  assign io_ready = r_io_ready;
  assign ram_ce   = r_ram_ce;
  assign ram_we   = r_ram_we;
  assign ram_addr = r_ram_addr;
  assign ram_din  = r_ram_din;
  assign pel_mask = r_pel_mask;

endmodule

// File: tb/tb_vga_dac_port_ctrl.sv
// Bench for vga_dac_port_ctrl: palette RAM model, directed host accesses,
// and a scoreboard monitor that checks io_dout on every io_ready.
module tb_vga_dac_port_ctrl;
  import vga_dac_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_ce, io_wr;
  logic [1:0] io_addr;
  logic [7:0] io_din, io_dout;
  logic       io_ready, ram_ce, ram_we;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout = 8'h00;
  logic [7:0] pel_mask;

  typedef struct {
    bit         chk;
    logic [7:0] exp;
    string      nm;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mem [1024] = '{default: 8'h00};
  int         cyc = 0, last_rdy = 0, bad_comp = 0, we_cnt = 0;
  int         n_checks = 0, n_errors = 0;

  vga_dac_port_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .io_ce   (io_ce),
    .io_wr   (io_wr),
    .io_addr (io_addr),
    .io_din  (io_din),
    .io_dout (io_dout),
    .io_ready(io_ready),
    .ram_ce  (ram_ce),
    .ram_we  (ram_we),
    .ram_addr(ram_addr),
    .ram_din (ram_din),
    .ram_dout(ram_dout),
    .pel_mask(pel_mask)
  );

  always #5 clk = ~clk;

  // Palette RAM port A: synchronous byte port, read data one cycle after ram_ce.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout      <= mem[ram_addr];
      if (ram_addr[1:0] == 2'd3) bad_comp <= bad_comp + 1;
    end
    if (ram_we) we_cnt <= we_cnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (io_ready) begin
      check("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.chk) check(e.nm, 32'(io_dout), 32'(e.exp));
      end
    end
  end

  task automatic access(input logic wr, input logic [1:0] a, input logic [7:0] d,
                        input bit chk, input logic [7:0] exp, input string nm);
    bit got;
    got = 1'b0;
    sb_q.push_back('{chk: chk, exp: exp, nm: nm});
    io_ce = 1'b1; io_wr = wr; io_addr = a; io_din = d;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (io_ready) begin
        got      = 1'b1;
        last_rdy = cyc;
      end
    end
    if (!got) check({"timeout ", nm}, 32'(got), 32'd1);
    @(posedge clk); #1;
    io_ce = 1'b0; io_wr = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    access(1'b1, a, d, 1'b0, 8'h00, "write");
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string nm);
    access(1'b0, a, 8'h00, 1'b1, exp, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [7:0] t4 [6];
    reset = 1'b1; io_ce = 1'b0; io_wr = 1'b0; io_addr = 2'd0; io_din = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {4'h0, io_dout, io_ready, ram_ce, ram_we, ram_addr, ram_din}, 32'd0);
    check("rst_pel_mask", 32'(pel_mask), 32'hFF);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: triplet write at index 0x10
    wr(DAC_WR_IDX, 8'h10);
    wr(DAC_DATA, 8'h3F);
    wr(DAC_DATA, 8'h00);
    wr(DAC_DATA, 8'h2A);
    check("mem_040", 32'(mem[10'h040]), 32'h3F);
    check("mem_041", 32'(mem[10'h041]), 32'h00);
    check("mem_042", 32'(mem[10'h042]), 32'h2A);
    rd(DAC_WR_IDX, 8'h11, "widx_after_triplet");

    // 2: upper bits of a component are stored as zero
    wr(DAC_DATA, 8'hFF);
    check("mem_044_masked", 32'(mem[10'h044]), 32'h3F);

    // 3: read-back with latency measured from the 3C7 write's ready
    wr(DAC_RD_IDX, 8'h10);
    c0 = last_rdy;
    rd(DAC_DATA, 8'h3F, "rb_r");
    check("rb_latency", 32'(last_rdy - c0), 32'd3);
    rd(DAC_DATA, 8'h00, "rb_g");
    rd(DAC_DATA, 8'h2A, "rb_b");
    rd(DAC_RD_IDX, 8'h03, "dac_state_read");

    // 4: write index wrap from 0xFF to 0x00
    t4 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    wr(DAC_WR_IDX, 8'hFF);
    for (int i = 0; i < 6; i++) wr(DAC_DATA, t4[i]);
    check("mem_3fc", 32'(mem[10'h3FC]), 32'h01);
    check("mem_3fd", 32'(mem[10'h3FD]), 32'h02);
    check("mem_3fe", 32'(mem[10'h3FE]), 32'h03);
    check("mem_000", 32'(mem[10'h000]), 32'h04);
    check("mem_001", 32'(mem[10'h001]), 32'h05);
    check("mem_002", 32'(mem[10'h002]), 32'h06);
    check("mem_3ff_untouched", 32'(mem[10'h3FF]), 32'h00);
    rd(DAC_WR_IDX, 8'h01, "widx_after_wrap");

    // 5: write to the prefetched address before reading it back
    wr(DAC_RD_IDX, 8'h05);
    wr(DAC_WR_IDX, 8'h05);
    wr(DAC_DATA, 8'h11);
    rd(DAC_DATA, 8'h11, "rb_after_overwrite");

    // 6: reset while the prefetch is in RD_WAIT
    wr(DAC_PEL_MASK, 8'h5A);
    rd(DAC_PEL_MASK, 8'h5A, "pel_mask_read");
    check("pel_mask_port", 32'(pel_mask), 32'h5A);
    wr(DAC_RD_IDX, 8'h00);
    check("pre_rst_in_wait", 32'(dut.r_state), 32'(RD_WAIT));
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_state_idle", 32'(dut.r_state), 32'(IDLE));
    check("midrst_io_ready", 32'(io_ready), 32'd0);
    check("midrst_pel_mask", 32'(pel_mask), 32'hFF);
    check("midrst_ram_we", 32'(ram_we), 32'd0);
    check("midrst_pf_valid", 32'(dut.r_pf_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rd(DAC_RD_IDX, 8'h00, "dac_state_after_rst");
    rd(DAC_PEL_MASK, 8'hFF, "pel_mask_after_rst");
    rd(DAC_DATA, 8'h04, "rb_fresh_after_rst");

    repeat (8) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("comp3_never_addressed", 32'(bad_comp), 32'd0);
    check("ram_we_pulses", 32'(we_cnt), 32'd11);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
